sram_arbiter: RTL and testbench

Two-requester arbiter and timing sequencer for the board's 32-bit asynchronous SRAM. The SRAM is built from two 16-bit chips that share an address bus: chip 1 carries data[31:16] and chip 0 carries data[15:0]. The block sits between the 68000 bus interface and a secondary bus master (boot loader / DMA) on one side, and the `ram_*` pins on the other. It grants round-robin, drives chip-enable, byte-lane, write and output strobes with a programmable wait count, and returns read data with a single-cycle acknowledge.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_rr_arbiter.sv | 36 +++
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter; grant is one-hot and combinational, last_grant is registered.
module sram_rr_arbiter
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                if (last_grant == 1'(REQ_DMA))
                    grant[REQ_CPU] = 1'b1;
                else
                    grant[REQ_DMA] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'(REQ_DMA);
        else if (|grant)
            last_grant <= grant[REQ_DMA] ? 1'(REQ_DMA) : 1'(REQ_CPU);
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates CPU and DMA masters onto a 2x16-bit async SRAM with programmable strobe timing.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [1:0]        cpu_be,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W:0]   dma_addr,
    input  logic [1:0]        dma_be,
    input  logic [15:0]       dma_wdata,
    output logic              dma_ack,
    output logic [15:0]       dma_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data_write,
    input  logic [31:0]       ram_data_read,
    output logic              ram_data_is_output,
    output logic [1:0]        ram_ce_n,
    output logic [1:0]        ram_ub_n,
    output logic [1:0]        ram_lb_n,
    output logic [1:0]        ram_we_n,
    output logic [1:0]        ram_oe_n
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cur_dma;
    logic             cur_we;
    logic             cur_upper;

    logic [1:0]       grant;
    logic             sel_dma;
    logic             sel_we;
    logic [ADDR_W:0]  sel_addr;
    logic [1:0]       sel_be;
    logic [15:0]      sel_wdata;
    logic [1:0]       sel_mask;
    logic [15:0]      read_half;

    sram_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({dma_req, cpu_req}),
        .enable (state == ST_IDLE),
        .grant  (grant)
    );

    assign sel_dma   = grant[REQ_DMA];
    assign sel_we    = sel_dma ? dma_we    : cpu_we;
    assign sel_addr  = sel_dma ? dma_addr  : cpu_addr;
    assign sel_be    = sel_dma ? dma_be    : cpu_be;
    assign sel_wdata = sel_dma ? dma_wdata : cpu_wdata;
    // Even word addresses live in chip 1 (upper half, big-endian).
    assign sel_mask  = sel_addr[0] ? 2'b01 : 2'b10;
    assign read_half = cur_upper ? ram_data_read[31:16] : ram_data_read[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            cur_dma            <= 1'b0;
            cur_we             <= 1'b0;
            cur_upper          <= 1'b0;
            ram_addr           <= '0;
            ram_data_write     <= '0;
            ram_data_is_output <= 1'b0;
            ram_ce_n           <= 2'b11;
            ram_ub_n           <= 2'b11;
            ram_lb_n           <= 2'b11;
            ram_we_n           <= 2'b11;
            ram_oe_n           <= 2'b11;
            cpu_ack            <= 1'b0;
            dma_ack            <= 1'b0;
            cpu_rdata          <= '0;
            dma_rdata          <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        state          <= ST_ACCESS;
                        cnt            <= CNT_W'(WAIT_CYCLES);
                        cur_dma        <= sel_dma;
                        cur_we         <= sel_we;
                        cur_upper      <= ~sel_addr[0];
                        ram_addr       <= sel_addr[ADDR_W:1];
                        ram_data_write <= {sel_wdata, sel_wdata};
                        ram_ce_n       <= ~sel_mask;
                        if (sel_we) begin
                            ram_ub_n           <= ~(sel_mask & {2{sel_be[1]}});
                            ram_lb_n           <= ~(sel_mask & {2{sel_be[0]}});
                            ram_we_n           <= (sel_be != 2'b00) ? ~sel_mask : 2'b11;
                            ram_oe_n           <= 2'b11;
                            ram_data_is_output <= 1'b1;
                        end else begin
                            ram_ub_n           <= ~sel_mask;
                            ram_lb_n           <= ~sel_mask;
                            ram_we_n           <= 2'b11;
                            ram_oe_n           <= ~sel_mask;
                            ram_data_is_output <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state              <= ST_RECOVER;
                        ram_ce_n           <= 2'b11;
                        ram_ub_n           <= 2'b11;
                        ram_lb_n           <= 2'b11;
                        ram_we_n           <= 2'b11;
                        ram_oe_n           <= 2'b11;
                        ram_data_is_output <= 1'b0;
                        if (cur_dma) begin
                            dma_ack <= 1'b1;
                            if (!cur_we)
                                dma_rdata <= read_half;
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!cur_we)
                                cpu_rdata <= read_half;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        // Release we_n one cycle early so address and data are held past its rising edge.
                        if (cnt == CNT_W'(1))
                            ram_we_n <= 2'b11;
                    end
                end
                ST_RECOVER: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural two-chip SRAM model.
module tb_sram_arbiter;

    localparam int AW = 18;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW:0]   cpu_addr;
    logic [1:0]    cpu_be;
    logic [15:0]   cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ack;
    logic [AW:0]   dma_addr;
    logic [1:0]    dma_be;
    logic [15:0]   dma_wdata, dma_rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data_write, ram_data_read;
    logic          ram_data_is_output;
    logic [1:0]    ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n;

    logic          d1_cpu_req, d1_cpu_ack, d1_dma_ack;
    logic [15:0]   d1_cpu_rdata, d1_dma_rdata;
    logic [AW-1:0] d1_ram_addr;
    logic [31:0]   d1_ram_data_write;
    logic          d1_ram_data_is_output;
    logic [1:0]    d1_ram_ce_n, d1_ram_ub_n, d1_ram_lb_n, d1_ram_we_n, d1_ram_oe_n;

    sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(AW)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_be(dma_be),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_data_write(ram_data_write), .ram_data_read(ram_data_read),
        .ram_data_is_output(ram_data_is_output), .ram_ce_n(ram_ce_n), .ram_ub_n(ram_ub_n),
        .ram_lb_n(ram_lb_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(d1_cpu_req), .cpu_we(1'b0), .cpu_addr('0), .cpu_be(2'b11),
        .cpu_wdata(16'h0000), .cpu_ack(d1_cpu_ack), .cpu_rdata(d1_cpu_rdata),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr('0), .dma_be(2'b00),
        .dma_wdata(16'h0000), .dma_ack(d1_dma_ack), .dma_rdata(d1_dma_rdata),
        .ram_addr(d1_ram_addr), .ram_data_write(d1_ram_data_write), .ram_data_read(32'hCAFE_1234),
        .ram_data_is_output(d1_ram_data_is_output), .ram_ce_n(d1_ram_ce_n), .ram_ub_n(d1_ram_ub_n),
        .ram_lb_n(d1_ram_lb_n), .ram_we_n(d1_ram_we_n), .ram_oe_n(d1_ram_oe_n)
    );

    // SRAM model: a write commits when we_n rises while ce_n is still low.
    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];
    logic [7:0]  pend_addr [2];
    logic [15:0] pend_data [2];
    logic [1:0]  pend_lanes [2];
    logic [1:0]  we_prev = 2'b11;
    int          we_low [2];

    assign ram_data_read = {
        (ram_ce_n[1] == 1'b0 && ram_oe_n[1] == 1'b0) ? mem1[ram_addr[7:0]] : 16'h0000,
        (ram_ce_n[0] == 1'b0 && ram_oe_n[0] == 1'b0) ? mem0[ram_addr[7:0]] : 16'h0000
    };

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (we_prev[c] == 1'b0 && ram_we_n[c] == 1'b1 && ram_ce_n[c] == 1'b0) begin
                if (c == 1) begin
                    if (pend_lanes[c][1]) mem1[pend_addr[c]][15:8] = pend_data[c][15:8];
                    if (pend_lanes[c][0]) mem1[pend_addr[c]][7:0]  = pend_data[c][7:0];
                end else begin
                    if (pend_lanes[c][1]) mem0[pend_addr[c]][15:8] = pend_data[c][15:8];
                    if (pend_lanes[c][0]) mem0[pend_addr[c]][7:0]  = pend_data[c][7:0];
                end
            end
            if (ram_we_n[c] == 1'b0 && ram_ce_n[c] == 1'b0) begin
                pend_addr[c]  = ram_addr[7:0];
                pend_data[c]  = (c == 1) ? ram_data_write[31:16] : ram_data_write[15:0];
                pend_lanes[c] = {~ram_ub_n[c], ~ram_lb_n[c]};
                we_low[c]     = we_low[c] + 1;
            end
            we_prev[c] = ram_we_n[c];
        end
    end

    int checks = 0;
    int errors = 0;

    logic [1:0]    snap_ce, snap_ub, snap_lb, snap_oe;
    logic [AW-1:0] snap_addr;
    logic          snap_out;
    logic          other_ack;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one transaction from IDLE; lat counts cycles from the sampling cycle to the ack.
    task automatic applyStimulus(input bit use_dma, input logic we, input logic [AW:0] addr,
                                 input logic [1:0] be, input logic [15:0] wdata,
                                 output int lat, output logic [15:0] rdata);
        @(posedge clk);
        #1;
        we_low[0] = 0;
        we_low[1] = 0;
        other_ack = 1'b0;
        lat       = -1;
        rdata     = 16'h0000;
        if (use_dma) begin
            dma_we = we; dma_addr = addr; dma_be = be; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                snap_ce = ram_ce_n; snap_ub = ram_ub_n; snap_lb = ram_lb_n;
                snap_oe = ram_oe_n; snap_addr = ram_addr; snap_out = ram_data_is_output;
            end
            if (use_dma ? cpu_ack : dma_ack) other_ack = 1'b1;
            if (use_dma ? dma_ack : cpu_ack) begin
                lat   = k;
                rdata = use_dma ? dma_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    int          lat;
    logic [15:0] rd;
    int          order [4];
    int          ack_k [4];
    int          n_acks;
    logic        overlap;
    logic        stray_ack;
    logic [1:0]  first_ack;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        we_low[0] = 0; we_low[1] = 0;
        mem0[2] = 16'hBEEF;
        mem0[0] = 16'h0F0F;
        mem0[1] = 16'hAAAA;
        mem1[0] = 16'h3456;
        mem1[2] = 16'h1111;

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = 2'b00; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_be = 2'b00; dma_wdata = '0;
        d1_cpu_req = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_strobes", {ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n}, 32'h3FF);
        checkOutput("rst_is_output", 32'(ram_data_is_output), 32'd0);
        checkOutput("rst_addr", 32'(ram_addr), 32'd0);
        checkOutput("rst_wdata", ram_data_write, 32'd0);
        checkOutput("rst_acks", {cpu_ack, dma_ack}, 32'd0);
        checkOutput("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);

        $display("[TB] CPU read from chip 0");
        applyStimulus(1'b0, 1'b0, 19'h00005, 2'b11, 16'h0000, lat, rd);
        checkOutput("rd_ce", 32'(snap_ce), 32'h2);
        checkOutput("rd_addr", 32'(snap_addr), 32'h2);
        checkOutput("rd_oe", 32'(snap_oe), 32'h2);
        checkOutput("rd_lanes", {snap_ub, snap_lb}, 32'hA);
        checkOutput("rd_latency", 32'(lat), 32'd4);
        checkOutput("rd_data", 32'(rd), 32'hBEEF);
        checkOutput("rd_no_dma_ack", 32'(other_ack), 32'd0);

        $display("[TB] CPU upper-byte write to chip 1");
        applyStimulus(1'b0, 1'b1, 19'h00000, 2'b10, 16'h12AB, lat, rd);
        checkOutput("wr_ce", 32'(snap_ce), 32'h1);
        checkOutput("wr_ub", 32'(snap_ub), 32'h1);
        checkOutput("wr_lb", 32'(snap_lb), 32'h3);
        checkOutput("wr_is_output", 32'(snap_out), 32'd1);
        checkOutput("wr_we1_cycles", 32'(we_low[1]), 32'd2);
        checkOutput("wr_we0_cycles", 32'(we_low[0]), 32'd0);
        checkOutput("wr_latency", 32'(lat), 32'd4);
        applyStimulus(1'b0, 1'b0, 19'h00000, 2'b11, 16'h0000, lat, rd);
        checkOutput("wr_readback", 32'(rd), 32'h1256);

        $display("[TB] DMA write with no byte enables");
        applyStimulus(1'b1, 1'b1, 19'h00003, 2'b00, 16'hFFFF, lat, rd);
        checkOutput("be0_we_cycles", 32'(we_low[0] + we_low[1]), 32'd0);
        checkOutput("be0_ce", 32'(snap_ce), 32'h2);
        checkOutput("be0_latency", 32'(lat), 32'd4);
        checkOutput("be0_mem", 32'(mem0[1]), 32'hAAAA);

        $display("[TB] simultaneous CPU and DMA reads");
        @(posedge clk);
        #1;
        cpu_we = 0; cpu_addr = 19'h00005; cpu_be = 2'b11; cpu_req = 1'b1;
        dma_we = 0; dma_addr = 19'h00001; dma_be = 2'b11; dma_req = 1'b1;
        n_acks = 0;
        overlap = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (cpu_ack && dma_ack) overlap = 1'b1;
            if (cpu_ack || dma_ack) begin
                order[n_acks] = dma_ack ? 1 : 0;
                ack_k[n_acks] = k;
                n_acks++;
                if (n_acks == 4) break;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        checkOutput("tie_count", 32'(n_acks), 32'd4);
        checkOutput("tie_order", {8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])}, 32'h00010001);
        checkOutput("tie_overlap", 32'(overlap), 32'd0);
        checkOutput("tie_first_k", 32'(ack_k[0]), 32'd4);
        checkOutput("tie_last_k", 32'(ack_k[3]), 32'd19);
        checkOutput("tie_rdata", {cpu_rdata, dma_rdata}, 32'hBEEF0F0F);

        $display("[TB] reset during write access");
        @(posedge clk);
        #1;
        cpu_we = 1; cpu_addr = 19'h00004; cpu_be = 2'b11; cpu_wdata = 16'h7777; cpu_req = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstw_in_access", 32'(ram_we_n), 32'h1);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstw_strobes", {ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n}, 32'h3FF);
        checkOutput("rstw_is_output", 32'(ram_data_is_output), 32'd0);
        reset = 1'b0;
        stray_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) stray_ack = 1'b1;
        end
        checkOutput("rstw_no_ack", 32'(stray_ack), 32'd0);
        checkOutput("rstw_mem", 32'(mem1[2]), 32'h1111);

        $display("[TB] first tie after reset");
        @(posedge clk);
        #1;
        cpu_we = 0; cpu_addr = 19'h00005; cpu_req = 1'b1;
        dma_we = 0; dma_addr = 19'h00001; dma_req = 1'b1;
        first_ack = 2'b00;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                first_ack = {cpu_ack, dma_ack};
                break;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        checkOutput("rst_tie_winner", 32'(first_ack), 32'h2);

        $display("[TB] back-to-back reads with one wait cycle");
        @(posedge clk);
        #1;
        d1_cpu_req = 1'b1;
        n_acks = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (d1_cpu_ack) begin
                ack_k[n_acks] = k;
                n_acks++;
                if (n_acks == 3) break;
            end
        end
        d1_cpu_req = 1'b0;
        checkOutput("w1_count", 32'(n_acks), 32'd3);
        checkOutput("w1_first_k", 32'(ack_k[0]), 32'd3);
        checkOutput("w1_period_a", 32'(ack_k[1] - ack_k[0]), 32'd4);
        checkOutput("w1_period_b", 32'(ack_k[2] - ack_k[1]), 32'd4);
        checkOutput("w1_rdata", 32'(d1_cpu_rdata), 32'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
